// File: rtl/fe_frombytes_stream_pkg.sv
// Shared field constants and types for the 2^255-19 limb datapath.
// Limb widths/offsets here are also used by the bytes-out serializer.
package fe_frombytes_stream_pkg;

    localparam int NLIMBS = 10;
    localparam int LIMB_W = 32;
    localparam int NBYTES = 32;

    localparam int unsigned LIMB_WID [NLIMBS] =
        '{26, 25, 26, 25, 26, 25, 26, 25, 26, 25};
    localparam int unsigned LIMB_OFF [NLIMBS] =
        '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};

    localparam logic [31:0] P0_LIMB = 32'h03FF_FFED;
    localparam logic [31:0] MASK26  = 32'h03FF_FFFF;
    localparam logic [31:0] MASK25  = 32'h01FF_FFFF;

    typedef logic [NLIMBS*LIMB_W-1:0] fe_limbs_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } fe_state_t;

    function automatic logic [31:0] limb_mask(input int i);
        return (LIMB_WID[i] == 26) ? MASK26 : MASK25;
    endfunction

endpackage

// File: rtl/fe_frombytes_stream_if.sv
// Byte-in / limbs-out handshake bundle for fe_frombytes_stream.
interface fe_frombytes_stream_if;
    import fe_frombytes_stream_pkg::*;

    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    fe_limbs_t  h;
    logic       h_sign;
    logic       h_noncanon;
    logic       h_valid;
    logic       h_ready;
    logic       frame_err;

    modport master (
        output in_byte, in_valid, in_last, h_ready,
        input  in_ready, h, h_sign, h_noncanon, h_valid, frame_err
    );

    modport slave (
        input  in_byte, in_valid, in_last, h_ready,
        output in_ready, h, h_sign, h_noncanon, h_valid, frame_err
    );

endinterface

// File: rtl/fe_unpack_limbs.sv
// Combinational 256-bit encoding -> 10 radix-2^25.5 limbs slice.
// FE_FROMBYTES_CANON_CHECK_EN adds the value >= p compare.
module fe_unpack_limbs
    import fe_frombytes_stream_pkg::*;
(
    input  logic [255:0] i_v,
    output fe_limbs_t    o_h,
    output logic         o_sign,
    output logic         o_noncanon
);

    always_comb begin
        o_h = '0;
        for (int i = 0; i < NLIMBS; i++) begin
            o_h[i*LIMB_W +: LIMB_W] =
                32'(i_v >> LIMB_OFF[i]) & limb_mask(i);
        end
    end

    assign o_sign = i_v[255];

`ifdef FE_FROMBYTES_CANON_CHECK_EN
    // >= p iff upper limbs saturate and h0 reaches p's low limb
    always_comb begin
        o_noncanon = (o_h[LIMB_W-1:0] >= P0_LIMB);
        for (int i = 1; i < NLIMBS; i++) begin
            if (o_h[i*LIMB_W +: LIMB_W] != limb_mask(i)) begin
                o_noncanon = 1'b0;
            end
        end
    end
`else
    assign o_noncanon = 1'b0;
`endif

endmodule

// File: rtl/fe_frombytes_stream.sv
// Byte-serial 32-byte LE field-element unpacker with one-entry output.
// Optional canonical check: FE_FROMBYTES_CANON_CHECK_EN.
module fe_frombytes_stream
    import fe_frombytes_stream_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    fe_frombytes_stream_if.slave   io
);

    fe_state_t    r_state;
    fe_state_t    w_state_nx;
    logic [4:0]   r_cnt;
    logic [4:0]   w_cnt_nx;
    logic [7:0]   r_buf [NBYTES-1];
    logic         w_hs;
    logic         w_load;
    logic         w_err;
    logic [255:0] w_v;
    fe_limbs_t    w_h;
    fe_limbs_t    r_h;
    logic         w_sign;
    logic         w_nc;
    logic         r_sign;
    logic         r_nc;
    logic         r_err;

    assign w_hs = io.in_valid & (r_state == COLLECT);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        w_err      = 1'b0;
        unique case (r_state)
            COLLECT: begin
                if (w_hs) begin
                    if (r_cnt == 5'd31 && io.in_last) begin
                        w_load     = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = HOLD;
                    end else if (r_cnt == 5'd31 || io.in_last) begin
                        w_err    = 1'b1;
                        w_cnt_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (io.h_ready) begin
                    w_state_nx = COLLECT;
                end
            end
        endcase
    end

    // Byte 31 is unpacked straight from the bus on the closing handshake
    always_comb begin
        w_v = '0;
        for (int k = 0; k < NBYTES-1; k++) begin
            w_v[8*k +: 8] = r_buf[k];
        end
        w_v[255:248] = io.in_byte;
    end

    fe_unpack_limbs u_unpack (
        .i_v        (w_v),
        .o_h        (w_h),
        .o_sign     (w_sign),
        .o_noncanon (w_nc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBYTES-1; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_hs && r_cnt != 5'd31) begin
            r_buf[r_cnt] <= io.in_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
            r_h     <= '0;
            r_sign  <= 1'b0;
            r_nc    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_err   <= w_err;
            if (w_load) begin
                r_h    <= w_h;
                r_sign <= w_sign;
                r_nc   <= w_nc;
            end
        end
    end

    assign io.in_ready   = (r_state == COLLECT);
    assign io.h_valid    = (r_state == HOLD);
    assign io.h          = r_h;
    assign io.h_sign     = r_sign;
    assign io.h_noncanon = r_nc;
    assign io.frame_err  = r_err;

endmodule

// File: tb/tb_fe_frombytes_stream.sv
// Scoreboard bench for fe_frombytes_stream: directed frames, errors,
// output stall and mid-frame reset.
module tb_fe_frombytes_stream;
    import fe_frombytes_stream_pkg::*;

`ifdef FE_FROMBYTES_CANON_CHECK_EN
    localparam bit NC_ON = 1'b1;
`else
    localparam bit NC_ON = 1'b0;
`endif

    typedef logic [7:0] frame_t [32];
    typedef struct {
        fe_limbs_t h;
        logic      sign;
        logic      nc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   err_seen;
    int   err_exp;
    exp_t sb [$];

    fe_frombytes_stream_if io ();

    fe_frombytes_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [319:0] act,
                       input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic fe_limbs_t mk(
        input logic [31:0] l0, input logic [31:0] l1,
        input logic [31:0] l2, input logic [31:0] l3,
        input logic [31:0] l4, input logic [31:0] l5,
        input logic [31:0] l6, input logic [31:0] l7,
        input logic [31:0] l8, input logic [31:0] l9);
        return {l9, l8, l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    // Monitor: pops the scoreboard on each output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (io.frame_err) err_seen++;
            if (io.h_valid && io.h_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got h_valid=1 want empty scoreboard");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("h", io.h, e.h);
                    chk("h_sign", 320'(io.h_sign), 320'(e.sign));
                    chk("h_noncanon", 320'(io.h_noncanon), 320'(e.nc));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok;
        bit done;
        done = 1'b0;
        @(negedge clk);
        io.in_byte  = b;
        io.in_valid = 1'b1;
        io.in_last  = last;
        for (int n = 0; n < 100 && !done; n++) begin
            ok = io.in_ready;
            @(posedge clk);
            if (ok) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
        end
    endtask

    task automatic run_frame(input frame_t f, input int last_at,
                             input bit good, input exp_t e);
        if (good) sb.push_back(e);
        else err_exp++;
        for (int k = 0; k <= last_at; k++) begin
            send_byte(f[k], k == last_at);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
        chk("lat_h_valid", 320'(io.h_valid), 320'(good));
        chk("lat_frame_err", 320'(io.frame_err), 320'(!good));
    endtask

    frame_t fz, f1, fff, fp, fpm1, fsp;
    exp_t   ez, e1, eff, ep, epm1, esp, enone;

    initial begin
        checks   = 0;
        errors   = 0;
        err_seen = 0;
        err_exp  = 0;
        rst_n       = 1'b0;
        io.in_byte  = '0;
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
        io.h_ready  = 1'b1;

        for (int k = 0; k < 32; k++) begin
            fz[k]   = 8'h00;
            f1[k]   = 8'h00;
            fff[k]  = 8'hFF;
            fp[k]   = 8'hFF;
            fpm1[k] = 8'hFF;
            fsp[k]  = 8'h00;
        end
        f1[0]    = 8'h01;
        fp[0]    = 8'hED;
        fp[31]   = 8'h7F;
        fpm1[0]  = 8'hEC;
        fpm1[31] = 8'h7F;
        fsp[3]   = 8'h80;
        fsp[16]  = 8'h01;
        fsp[31]  = 8'h80;

        ez   = '{h: '0, sign: 1'b0, nc: 1'b0};
        enone = ez;
        e1   = '{h: mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), sign: 1'b0, nc: 1'b0};
        eff  = '{h: mk(32'h3FFFFFF, 32'h1FFFFFF, 32'h3FFFFFF,
                       32'h1FFFFFF, 32'h3FFFFFF, 32'h1FFFFFF,
                       32'h3FFFFFF, 32'h1FFFFFF, 32'h3FFFFFF,
                       32'h1FFFFFF), sign: 1'b1, nc: NC_ON};
        ep   = '{h: mk(32'h3FFFFED, 32'h1FFFFFF, 32'h3FFFFFF,
                       32'h1FFFFFF, 32'h3FFFFFF, 32'h1FFFFFF,
                       32'h3FFFFFF, 32'h1FFFFFF, 32'h3FFFFFF,
                       32'h1FFFFFF), sign: 1'b0, nc: NC_ON};
        epm1 = '{h: mk(32'h3FFFFEC, 32'h1FFFFFF, 32'h3FFFFFF,
                       32'h1FFFFFF, 32'h3FFFFFF, 32'h1FFFFFF,
                       32'h3FFFFFF, 32'h1FFFFFF, 32'h3FFFFFF,
                       32'h1FFFFFF), sign: 1'b0, nc: 1'b0};
        esp  = '{h: mk(0, 32'h20, 0, 0, 0, 1, 0, 0, 0, 0),
                 sign: 1'b1, nc: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_h", io.h, '0);
        chk("rst_h_valid", 320'(io.h_valid), 320'(0));
        chk("rst_frame_err", 320'(io.frame_err), 320'(0));
        chk("rst_h_sign", 320'(io.h_sign), 320'(0));
        chk("rst_h_noncanon", 320'(io.h_noncanon), 320'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 320'(io.in_ready), 320'(1));

        run_frame(fz, 31, 1'b1, ez);
        run_frame(f1, 31, 1'b1, e1);
        run_frame(fff, 31, 1'b1, eff);
        run_frame(fp, 31, 1'b1, ep);
        run_frame(fpm1, 31, 1'b1, epm1);
        run_frame(fsp, 31, 1'b1, esp);

        // Early in_last, then missing in_last, each followed by a good frame
        run_frame(fff, 5, 1'b0, enone);
        run_frame(f1, 31, 1'b1, e1);
        for (int k = 0; k < 32; k++) send_byte(fff[k], 1'b0);
        err_exp++;
        @(negedge clk);
        io.in_valid = 1'b0;
        chk("nolast_frame_err", 320'(io.frame_err), 320'(1));
        chk("nolast_h_valid", 320'(io.h_valid), 320'(0));
        run_frame(fsp, 31, 1'b1, esp);

        // Output stall
        @(posedge clk);
        #1 io.h_ready = 1'b0;
        run_frame(fp, 31, 1'b1, ep);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_h", io.h, ep.h);
            chk("stall_in_ready", 320'(io.in_ready), 320'(0));
            chk("stall_h_valid", 320'(io.h_valid), 320'(1));
        end
        @(posedge clk);
        #1 io.h_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_xfer_in_ready", 320'(io.in_ready), 320'(1));
        chk("post_xfer_h_valid", 320'(io.h_valid), 320'(0));
        chk("post_xfer_h_kept", io.h, ep.h);

        // Reset while byte 17 is being collected
        for (int k = 0; k < 17; k++) send_byte(fff[k], 1'b0);
        @(negedge clk);
        io.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_h", io.h, '0);
        chk("midrst_h_sign", 320'(io.h_sign), 320'(0));
        chk("midrst_h_noncanon", 320'(io.h_noncanon), 320'(0));
        chk("midrst_h_valid", 320'(io.h_valid), 320'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(fsp, 31, 1'b1, esp);

        for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("sb_drained", 320'(sb.size()), 320'(0));
        chk("frame_err_count", 320'(err_seen), 320'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_frombytes_stream.md
# fe_frombytes_stream

Byte-serial front end for the field-element datapath. Accepts a 32-byte little-endian encoding of a field element mod p = 2^255−19 over a valid/ready byte stream. Unpacks it into the 10-limb radix-2^25.5 form: 320-bit packed, limb i in bits [32i+31:32i]. Presents the result on a single-entry output register. Sits directly upstream of the field arithmetic and of the bytes-out serializer, and performs the inverse of the limb-to-byte packing.

## Interface
- No parameters; limb layout is fixed by the field.
- clk  in  1  — single clock; all state on rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- in_byte  in  8  — encoding byte; byte 0 is first, least significant.
- in_valid  in  1  — in_byte is valid.
- in_last  in  1  — marks the final byte of a frame; qualified by in_valid.
- in_ready  out  1  — block accepts a byte this cycle.
- h  out  320  — packed signed 32-bit limbs h0..h9, h0 in [31:0].
- h_sign  out  1  — bit 255 of the encoding (bit 7 of byte 31).
- h_noncanon  out  1  — encoded value ≥ p. Present only with the macro; tied 0 otherwise.
- h_valid  out  1  — h, h_sign and h_noncanon are valid.
- h_ready  in  1  — consumer takes the result.
- frame_err  out  1  — one-cycle pulse on a malformed frame.

## Operation
- States: COLLECT, HOLD.
- **Reset:** state=COLLECT, byte counter=0, h=0, h_sign=0, h_noncanon=0, h_valid=0, frame_err=0, byte buffer cleared.
- **COLLECT:**
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_byte to buffer[cnt] and increments the 5-bit counter.
- **Valid frame end:** handshake with cnt=31 and in_last=1.
  - Unpack and register outputs.
  - counter→0, state→HOLD.
- **Frame errors:**
  - Handshake with in_last=1 and cnt≠31: pulse frame_err, discard the frame, counter→0, stay in COLLECT.
  - Handshake with cnt=31 and in_last=0: same error handling.
- **Unpack:** the 256-bit value v = Σ buffer[k]·2^(8k). Bit 255 goes to h_sign and is excluded from the limbs.
  - Limb i = v[off_i +: w_i], zero-extended to 32 bits.
  - Widths w = 26,25,26,25,26,25,26,25,26,25.
  - Offsets off = 0,26,51,77,102,128,153,179,204,230.
  - No carry or reduction is applied. Every limb lies within its width, so it is non-negative.
- **HOLD:**
  - in_ready=0, h_valid=1.
  - Outputs are stable until h_ready. On h_valid & h_ready: h_valid→0, state→COLLECT.
  - h keeps its last value after the transfer; only h_valid drops.
- in_valid with in_ready=0 is ignored; upstream holds the byte.

## Timing
- Throughput: 32 byte-cycles plus 1 output cycle per element. No overlap: the next frame's first byte is accepted the cycle after the output handshake.
- Latency: last byte accepted at edge N → h_valid=1 after edge N (visible in cycle N+1).
- in_ready is a pure function of state; it never depends combinationally on in_valid.
- frame_err is high for exactly the cycle after the offending handshake.
- h_ready held high in HOLD → transfer completes in that cycle; in_ready=1 in the following cycle.
- Reset mid-frame or mid-HOLD: the partial frame and any pending output are lost. Outputs return to reset values asynchronously.

## Configuration
- **FE_FROMBYTES_CANON_CHECK_EN**
  - Defined: h_noncanon is registered with h. It is 1 iff h1..h9 are each all-ones in their width and h0 ≥ 0x3FFFFED. h_sign is not considered.
  - Undefined: h_noncanon is constant 0 and no compare logic is built.

## Structure
- Shared field package holds:
  - NLIMBS=10 and LIMB_W=32.
  - Limb width and offset constant arrays, shared with the bytes-out serializer.
  - P0_LIMB=0x3FFFFED, MASK26, MASK25.
  - The packed-limb typedef.
- One sub-module is natural: fe_unpack_limbs. It is the combinational 256-bit → 10-limb slice plus the optional canonical compare. The top holds the FSM, counter, buffer and output register.

## Test plan
- All-zero frame, last on byte 31 → h=0, h_sign=0, h_noncanon=0; h_valid one cycle after the last byte.
- Byte0=0x01, rest 0 → h0=1, other limbs 0.
- All bytes 0xFF → even limbs 0x3FFFFFF, odd limbs 0x1FFFFFF, h_sign=1, h_noncanon=1 (macro on) / 0 (macro off).
- p (0xED, 30×0xFF, 0x7F) → h0=0x3FFFFED, other limbs max, h_sign=0, h_noncanon=1. The same frame with byte0=0xEC → h0=0x3FFFFEC, h_noncanon=0.
- in_last on byte 5 → frame_err pulse, no h_valid. A following correct frame decodes normally.
- h_ready held low 10 cycles → h stable and in_ready=0 throughout. Reset asserted mid-frame (byte 17) → all outputs 0, and the next full frame decodes correctly.
